// File: rtl/seg7_bcd_counter_pkg.sv
// Shared types, glyph table and segment encoder for the BCD counter block.
//   seg7_t      : one display digit, {dp,g,f,e,d,c,b,a}
//   bcd_t       : one BCD digit
//   SEG_GLYPH   : active-high glyphs for 0..9, dp off
//   SEG_BLANK   : active-high "all segments off"
//   seg7_encode : glyph lookup with blanking and output polarity
package seg7_bcd_counter_pkg;

    typedef logic [7:0] seg7_t;
    typedef logic [3:0] bcd_t;

    localparam seg7_t SEG_GLYPH [0:9] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
        8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
    };

    localparam seg7_t SEG_BLANK = 8'h00;

    // Codes above 9 cannot reach the display (load saturates), but decode
    // them as blank rather than indexing past the table.
    function automatic seg7_t seg7_encode(bcd_t value, logic blank, logic active_low);
        seg7_t s;
        if (blank || (value > 4'd9)) begin
            s = SEG_BLANK;
        end else begin
            s = SEG_GLYPH[value];
        end
        return active_low ? ~s : s;
    endfunction

endpackage

// File: rtl/seg7_bcd_counter_if.sv
// Control/status bundle of the BCD counter.
//   master : drives run, dir, clr, load, load_val, freeze; reads the outputs
//   slave  : the counter; reads the controls, drives tick_out, wrap_out,
//            bcd_out, seg7_out
// Protocol: there is no handshake. Every control is a level sampled on each
// rising clk edge; clr and load act on every edge they are high, and
// tick_out/wrap_out are single-cycle pulses with no back-pressure.
interface seg7_bcd_counter_if #(
    parameter int DIGITS = 2
);
    import seg7_bcd_counter_pkg::*;

    logic                run;
    logic                dir;
    logic                clr;
    logic                load;
    logic [4*DIGITS-1:0] load_val;
    logic                freeze;
    logic                tick_out;
    logic                wrap_out;
    logic [4*DIGITS-1:0] bcd_out;
    seg7_t               seg7_out [DIGITS-1:0];

    modport master (
        output run, dir, clr, load, load_val, freeze,
        input  tick_out, wrap_out, bcd_out, seg7_out
    );

    modport slave (
        input  run, dir, clr, load, load_val, freeze,
        output tick_out, wrap_out, bcd_out, seg7_out
    );

endinterface

// File: rtl/seg7_bcd_counter_bcd_digit.sv
// One BCD digit of the up/down counter.
//   clk, n_rst : clock, synchronous active-low reset
//   en         : step this digit on this edge
//   dir        : 0 up, 1 down
//   clr, load  : synchronous clear / parallel load (clr wins)
//   d          : load value, saturated to 9
//   q          : current digit
//   carry      : q is at its rollover value for the current direction
module seg7_bcd_counter_bcd_digit
    import seg7_bcd_counter_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic en,
    input  logic dir,
    input  logic clr,
    input  logic load,
    input  bcd_t d,
    output bcd_t q,
    output logic carry
);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= (d > 4'd9) ? 4'd9 : d;
        end else if (en) begin
            if (dir) begin
                q <= (q == 4'd0) ? 4'd9 : q - 4'd1;
            end else begin
                q <= (q == 4'd9) ? 4'd0 : q + 4'd1;
            end
        end
    end

    assign carry = dir ? (q == 4'd0) : (q == 4'd9);

endmodule

// File: rtl/seg7_bcd_counter.sv
// N-digit BCD up/down counter with prescaler and registered 7-segment outputs.
//   clk, n_rst : clock, synchronous active-low reset
//   bus        : slave side of seg7_bcd_counter_if (controls in, status out)
// Per-edge priority: reset > freeze > clr > load > tick. The count steps on
// the same edge that registers tick_out, so bcd_out is new while tick_out is
// high; seg7_out is decoded from bcd_out one edge later.
module seg7_bcd_counter
    import seg7_bcd_counter_pkg::*;
#(
    parameter int FREQUENCY      = 50_000_000,
    parameter int TICK_HZ        = 1,
    parameter int DIGITS         = 2,
    parameter bit BLANK_LZ       = 1'b0,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input logic               clk,
    input logic               n_rst,
    seg7_bcd_counter_if.slave bus
);

    localparam int DIV   = FREQUENCY / TICK_HZ;
    localparam int PSC_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(DIV - 1);

    if (DIV < 2) begin : g_div_check
        $error("seg7_bcd_counter: FREQUENCY/TICK_HZ must be at least 2");
    end
    if ((DIGITS < 1) || (DIGITS > 8)) begin : g_digits_check
        $error("seg7_bcd_counter: DIGITS must be 1..8");
    end

    logic [PSC_W-1:0]    psc;
    logic                tick;
    logic                clr_g;
    logic                load_g;
    logic [DIGITS:0]     en_chain;
    logic [DIGITS-1:0]   carry;
    logic [4*DIGITS-1:0] bcd_q;
    logic [DIGITS-1:0]   blank;
    logic                tick_q;
    logic                wrap_q;
    seg7_t               seg_q [DIGITS-1:0];

    // Freeze masks everything; clr and load swallow a coinciding tick.
    assign clr_g  = bus.clr & ~bus.freeze;
    assign load_g = bus.load & ~bus.freeze;
    assign tick   = bus.run & ~bus.freeze & ~bus.clr & ~bus.load & (psc == PSC_LAST);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            psc <= '0;
        end else if (!bus.freeze) begin
            if (bus.clr || bus.load) begin
                psc <= '0;
            end else if (bus.run) begin
                psc <= (psc == PSC_LAST) ? '0 : psc + 1'b1;
            end
        end
    end

    // Ripple enable: a digit steps when every lower digit is rolling over.
    assign en_chain[0] = tick;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        seg7_bcd_counter_bcd_digit u_digit (
            .clk   (clk),
            .n_rst (n_rst),
            .en    (en_chain[k]),
            .dir   (bus.dir),
            .clr   (clr_g),
            .load  (load_g),
            .d     (bus.load_val[4*k +: 4]),
            .q     (bcd_q[4*k +: 4]),
            .carry (carry[k])
        );
        assign en_chain[k+1] = en_chain[k] & carry[k];
    end

    // The enable leaving the top digit is exactly "whole count wraps".
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            tick_q <= tick;
            wrap_q <= en_chain[DIGITS];
        end
    end

    // Scan from the top digit down: a digit is a leading zero while every
    // digit above it (and itself) is zero. Digit 0 always shows.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        blank      = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero & (bcd_q[4*k +: 4] == 4'd0);
            blank[k]   = BLANK_LZ && (k != 0) && upper_zero;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < DIGITS; k++) begin
            if (!n_rst) begin
                seg_q[k] <= seg7_encode(4'd0, BLANK_LZ && (k != 0), SEG_ACTIVE_LOW);
            end else if (!bus.freeze) begin
                seg_q[k] <= seg7_encode(bcd_q[4*k +: 4], blank[k], SEG_ACTIVE_LOW);
            end
        end
    end

    assign bus.tick_out = tick_q;
    assign bus.wrap_out = wrap_q;
    assign bus.bcd_out  = bcd_q;
    assign bus.seg7_out = seg_q;

endmodule

// File: tb/tb_seg7_bcd_counter.sv
module tb_seg7_bcd_counter;

    localparam int DIV = 10;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    seg7_bcd_counter_if #(.DIGITS(2)) bus1 ();
    seg7_bcd_counter_if #(.DIGITS(3)) bus2 ();

    seg7_bcd_counter #(
        .FREQUENCY(10), .TICK_HZ(1), .DIGITS(2), .BLANK_LZ(1'b0), .SEG_ACTIVE_LOW(1'b1)
    ) dut1 (.clk(clk), .n_rst(n_rst), .bus(bus1));

    seg7_bcd_counter #(
        .FREQUENCY(10), .TICK_HZ(1), .DIGITS(3), .BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b1)
    ) dut2 (.clk(clk), .n_rst(n_rst), .bus(bus2));

    // ---------------- scoreboard counters ----------------
    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The count is an integer 0..10^N-1; digits, glyphs and blanking are
    // derived from it arithmetically.
    logic [7:0] glyph [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                               8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    typedef struct packed {
        int cnt;
        int psc;
        bit tick;
        bit wrap;
        int seg_cnt;   // count currently shown on the segments
    } mstate_t;

    mstate_t m1 = '0;
    mstate_t m2 = '0;

    function automatic int p10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [31:0] to_bcd(input int v, input int nd);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < nd; k++) r[4*k +: 4] = 4'((v / p10(k)) % 10);
        return r;
    endfunction

    function automatic logic [7:0] exp_seg(input int v, input int k, input bit blz);
        logic [7:0] lit;
        if (blz && (k > 0) && (v < p10(k))) lit = 8'h00;
        else lit = glyph[(v / p10(k)) % 10];
        return ~lit;
    endfunction

    function automatic int sat_val(input logic [31:0] lv, input int nd);
        int r;
        int nib;
        r = 0;
        for (int k = 0; k < nd; k++) begin
            nib = int'(lv[4*k +: 4]);
            if (nib > 9) nib = 9;
            r = r + nib * p10(k);
        end
        return r;
    endfunction

    function automatic mstate_t model_step(input mstate_t s, input int nd, input bit rst_n,
                                           input bit frz, input bit run, input bit dir,
                                           input bit clr, input bit load, input logic [31:0] lv);
        mstate_t n;
        int top;
        n   = s;
        top = p10(nd) - 1;
        if (!rst_n) begin
            n = '0;
        end else if (frz) begin
            n.tick = 1'b0;
            n.wrap = 1'b0;
        end else begin
            n.seg_cnt = s.cnt;
            n.tick    = 1'b0;
            n.wrap    = 1'b0;
            if (clr) begin
                n.cnt = 0;
                n.psc = 0;
            end else if (load) begin
                n.cnt = sat_val(lv, nd);
                n.psc = 0;
            end else if (run) begin
                n.psc = (s.psc + 1) % DIV;
                if (s.psc == DIV - 1) begin
                    n.tick = 1'b1;
                    if (!dir) begin
                        n.wrap = (s.cnt == top);
                        n.cnt  = (s.cnt + 1) % (top + 1);
                    end else begin
                        n.wrap = (s.cnt == 0);
                        n.cnt  = (s.cnt + top) % (top + 1);
                    end
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m1 = model_step(m1, 2, n_rst, bus1.freeze, bus1.run, bus1.dir, bus1.clr, bus1.load,
                        32'(bus1.load_val));
        m2 = model_step(m2, 3, n_rst, bus2.freeze, bus2.run, bus2.dir, bus2.clr, bus2.load,
                        32'(bus2.load_val));
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("tick1", bus1.tick_out, m1.tick);
            check("wrap1", bus1.wrap_out, m1.wrap);
            check("bcd1", bus1.bcd_out, to_bcd(m1.cnt, 2));
            for (int k = 0; k < 2; k++) check("seg1", bus1.seg7_out[k], exp_seg(m1.seg_cnt, k, 1'b0));
            check("tick2", bus2.tick_out, m2.tick);
            check("wrap2", bus2.wrap_out, m2.wrap);
            check("bcd2", bus2.bcd_out, to_bcd(m2.cnt, 3));
            for (int k = 0; k < 3; k++) check("seg2", bus2.seg7_out[k], exp_seg(m2.seg_cnt, k, 1'b1));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wait_tick(input int limit, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while ((bus1.tick_out !== 1'b1) && (n < limit));
        check("tick_seen", bus1.tick_out, 1'b1);
    endtask

    logic [7:0] p2_exp [6] = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h99};

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ticks;
        int wraps;
        int frz1;
        int frz2;

        n_rst = 1'b0;
        bus1.run = 1'b1; bus1.dir = 1'b0; bus1.clr = 1'b0; bus1.load = 1'b0;
        bus1.freeze = 1'b0; bus1.load_val = '0;
        bus2.run = 1'b1; bus2.dir = 1'b0; bus2.clr = 1'b0; bus2.load = 1'b0;
        bus2.freeze = 1'b0; bus2.load_val = '0;

        cyc();
        chk_en = 1'b1;
        cyc();
        cyc();
        check("rst_bcd", bus1.bcd_out, 8'h00);
        check("rst_tick", bus1.tick_out, 1'b0);
        check("rst_seg0", bus1.seg7_out[0], 8'hC0);
        check("rst_seg1", bus1.seg7_out[1], 8'hC0);
        check("rst2_seg0", bus2.seg7_out[0], 8'hC0);
        check("rst2_seg2", bus2.seg7_out[2], 8'hFF);
        n_rst = 1'b1;

        // Free-running up count through one full wrap.
        ticks = 0;
        wraps = 0;
        for (int i = 1; i <= 1000; i++) begin
            cyc();
            if (bus1.tick_out === 1'b1) ticks++;
            if (bus1.wrap_out === 1'b1) wraps++;
            if (i == 500) check("p1_bcd50", bus1.bcd_out, 8'h50);
            if (i == 75) begin
                check("blank_007_d2", bus2.seg7_out[2], 8'hFF);
                check("blank_007_d1", bus2.seg7_out[1], 8'hFF);
                check("blank_007_d0", bus2.seg7_out[0], 8'hF8);
            end
        end
        check("p1_ticks", 64'(ticks), 64'd100);
        check("p1_wraps", 64'(wraps), 64'd1);
        check("p1_bcd_end", bus1.bcd_out, 8'h00);
        cyc();
        check("noblank_100_d2", bus2.seg7_out[2], 8'hF9);
        check("noblank_100_d1", bus2.seg7_out[1], 8'hC0);
        check("noblank_100_d0", bus2.seg7_out[0], 8'hC0);

        // Load 05 and count down through the 00 -> 99 wrap.
        bus1.load_val = 8'h05;
        bus1.load = 1'b1;
        bus1.dir = 1'b1;
        cyc();
        bus1.load = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wait_tick(30, n);
            check("p2_bcd", bus1.bcd_out, p2_exp[i]);
            check("p2_wrap", bus1.wrap_out, (i == 5));
        end
        cyc();
        check("p2_seg0_9", bus1.seg7_out[0], 8'h90);
        check("p2_seg1_9", bus1.seg7_out[1], 8'h90);

        // Saturating load landing on the internal tick cycle.
        wait_tick(30, n);
        repeat (9) cyc();
        bus1.load_val = 8'hAF;
        bus1.load = 1'b1;
        cyc();
        bus1.load = 1'b0;
        check("p3_bcd_sat", bus1.bcd_out, 8'h99);
        check("p3_tick_drop", bus1.tick_out, 1'b0);
        wait_tick(30, n);
        check("p3_period", 64'(n), 64'd10);
        check("p3_bcd_next", bus1.bcd_out, 8'h98);

        // Freeze at prescaler 4, count 12; controls are ignored while frozen.
        bus1.dir = 1'b0;
        bus1.load_val = 8'h12;
        bus1.load = 1'b1;
        cyc();
        bus1.load = 1'b0;
        repeat (4) cyc();
        bus1.freeze = 1'b1;
        for (int i = 0; i < 37; i++) begin
            if (i == 10) begin bus1.clr = 1'b1; bus1.run = 1'b0; end
            if (i == 15) begin bus1.clr = 1'b0; bus1.load = 1'b1; end
            if (i == 20) begin bus1.load = 1'b0; bus1.run = 1'b1; end
            cyc();
            check("frz_tick", bus1.tick_out, 1'b0);
            check("frz_bcd", bus1.bcd_out, 8'h12);
            check("frz_seg0", bus1.seg7_out[0], 8'hA4);
            check("frz_seg1", bus1.seg7_out[1], 8'hF9);
        end
        bus1.freeze = 1'b0;
        wait_tick(30, n);
        check("frz_resume_cycles", 64'(n), 64'd6);
        check("frz_resume_bcd", bus1.bcd_out, 8'h13);

        // Clear coinciding with the tick at count 42.
        bus1.load_val = 8'h42;
        bus1.load = 1'b1;
        cyc();
        bus1.load = 1'b0;
        repeat (9) cyc();
        bus1.clr = 1'b1;
        cyc();
        bus1.clr = 1'b0;
        check("clr_bcd", bus1.bcd_out, 8'h00);
        check("clr_tick", bus1.tick_out, 1'b0);
        check("clr_wrap", bus1.wrap_out, 1'b0);
        wait_tick(30, n);
        check("clr_period", 64'(n), 64'd10);
        check("clr_bcd_next", bus1.bcd_out, 8'h01);

        // Randomised mix of every control, checked against the model.
        frz1 = 0;
        frz2 = 0;
        for (int c = 0; c < 4000; c++) begin
            n_rst = ($urandom_range(0, 399) != 0);
            bus1.run = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) bus1.dir = ~bus1.dir;
            bus1.clr = ($urandom_range(0, 99) == 0);
            bus1.load = ($urandom_range(0, 49) == 0);
            bus1.load_val = 8'($urandom);
            if (frz1 > 0) frz1--;
            else if ($urandom_range(0, 49) == 0) frz1 = $urandom_range(1, 25);
            bus1.freeze = (frz1 > 0);
            bus2.run = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) bus2.dir = ~bus2.dir;
            bus2.clr = ($urandom_range(0, 99) == 0);
            bus2.load = ($urandom_range(0, 49) == 0);
            bus2.load_val = 12'($urandom);
            if (frz2 > 0) frz2--;
            else if ($urandom_range(0, 49) == 0) frz2 = $urandom_range(1, 25);
            bus2.freeze = (frz2 > 0);
            cyc();
        end

        n_rst = 1'b1;
        bus1.freeze = 1'b0; bus1.clr = 1'b0; bus1.load = 1'b0;
        bus2.freeze = 1'b0; bus2.clr = 1'b0; bus2.load = 1'b0;
        repeat (20) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
